result_recorder: RTL
====================

RESULT_RECORDER -- requirements
Module: result_recorder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, setting the number of history entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 50_000_000, setting the browse inactivity timeout in clock cycles.
REQ-003 The block SHALL have port i_clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_number  input  4  live value from the random generator.
REQ-006 The block SHALL have port i_idle  input  1  generator idle flag; its 0->1 transition marks a final result.
REQ-007 The block SHALL have port i_prev  input  1  single-cycle pulse: step to an older entry.
REQ-008 The block SHALL have port i_next  input  1  single-cycle pulse: step to a newer entry.
REQ-009 The block SHALL have port i_clear  input  1  single-cycle pulse: erase the history.
REQ-010 The block SHALL have port o_seg  output  7  active-low segments {g,f,e,d,c,b,a} for o_shown.
REQ-011 The block SHALL have port o_shown  output  4  value currently displayed.
REQ-012 The block SHALL have port o_age  output  log2(DEPTH)  age of the browsed entry (0 = newest).
REQ-013 The block SHALL have port o_count  output  log2(DEPTH)+1  number of valid entries.
REQ-014 The block SHALL have port o_browse  output  1  high in BROWSE state.
REQ-015 The block SHALL have port o_new  output  1  one-cycle pulse after a capture.

Function
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the inputs that cause them.
REQ-017 The block SHALL register i_idle into idle_d, reset value 1, so that the first cycle after reset does not capture.
REQ-018 A capture SHALL occur when i_idle=1 and idle_d=0: i_number in that cycle is written at wr_ptr, wr_ptr increments modulo DEPTH, count increments and saturates at DEPTH, and o_new=1 in the next cycle.
REQ-019 When the buffer is full, a capture SHALL overwrite the oldest entry, with count held at DEPTH.
REQ-020 The state machine SHALL have exactly two states: LIVE (reset state) and BROWSE.
REQ-021 In LIVE, o_shown SHALL follow i_number, and o_age=0.
REQ-022 In LIVE, i_prev with count>0 SHALL enter BROWSE at age 0; i_prev with count=0 and i_next SHALL be ignored.
REQ-023 In BROWSE, o_shown SHALL equal history[(wr_ptr-1-age) mod DEPTH].
REQ-024 In BROWSE, i_prev SHALL increment age, saturating at count-1.
REQ-025 In BROWSE, i_next SHALL decrement age; i_next at age 0 SHALL return to LIVE.
REQ-026 Simultaneous i_prev and i_next SHALL be ignored in both states.
REQ-027 The BROWSE timeout counter SHALL clear on entry to BROWSE and on any accepted button; on reaching TIMEOUT-1 the block SHALL return to LIVE with age 0.
REQ-028 A capture during BROWSE SHALL increment age (saturating at DEPTH-1), so the same entry stays displayed unless that entry was itself overwritten.
REQ-029 i_clear SHALL set count=0, wr_ptr=0 and age=0, and force LIVE.
REQ-030 A capture in the same cycle as i_clear SHALL be dropped, and o_new SHALL stay 0.
REQ-031 i_clear SHALL have priority over i_prev and i_next.
REQ-032 o_seg SHALL be the hex glyph of o_shown, active-low, e.g. 0 -> 7'b1000000, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.

Reset
REQ-033 While i_rst=0, the block SHALL hold: state=LIVE, count=0, wr_ptr=0, age=0, timeout counter=0, idle_d=1, o_shown=0, o_seg=7'b1000000, o_new=0, o_browse=0.
REQ-034 History contents SHALL be don't-care after reset, and SHALL never be displayed while count=0.
REQ-035 Reset asserted mid-BROWSE or mid-capture SHALL take effect immediately, with no capture completing.

Verification
REQ-036 Drive i_idle 1->0->1 with i_number=5 on the rising cycle -> o_new pulses once, o_count=1, then i_prev -> o_browse=1, o_shown=5, o_seg=7'b0010010.
REQ-037 Make 10 captures of values 1..10 with DEPTH=8 -> o_count=8; pressing i_prev 9 times gives ages 0..7 showing 10 down to 3, and age saturates at 7.
REQ-038 In BROWSE at age 2, capture value 0xC -> o_age=3 and o_shown unchanged.
REQ-039 With TIMEOUT=16, enter BROWSE with no buttons -> return to LIVE exactly 16 cycles after entry, o_shown tracks i_number.
REQ-040 Pulse i_clear and a capture edge in the same cycle with count=4 -> o_count=0, o_new=0, LIVE; a subsequent i_prev is ignored.
REQ-041 Assert i_rst during BROWSE with count=3 -> all outputs take their reset values asynchronously; i_idle held at 1 after release causes no capture.

Source files
------------

// File: rtl/result_recorder.sv
// rtl/result_recorder.sv - history of generator results with browse mode and 7-segment output
// Captures each final result into a circular buffer and lets the user step back through it.
module result_recorder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [3:0]                 i_number,
  input  logic                       i_idle,
  input  logic                       i_prev,
  input  logic                       i_next,
  input  logic                       i_clear,
  output logic [6:0]                 o_seg,
  output logic [3:0]                 o_shown,
  output logic [$clog2(DEPTH)-1:0]   o_age,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_browse,
  output logic                       o_new
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {S_LIVE, S_BROWSE} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_n;
  logic [CW-1:0] r_count, w_count_n;
  logic [AW-1:0] r_age, w_age_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          r_idle_d;
  logic [3:0]    r_shown, w_shown_n;
  logic [6:0]    r_seg;
  logic          r_new, w_new_n;
  logic          w_we;
  logic          w_cap;
  logic          w_btn_prev, w_btn_next;
  logic [AW-1:0] w_idx;
  logic [3:0]    r_hist [DEPTH];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign w_cap      = i_idle & ~r_idle_d;
  assign w_btn_prev = i_prev & ~i_next;
  assign w_btn_next = i_next & ~i_prev;

  always_comb begin
    w_state_n  = r_state;
    w_wr_ptr_n = r_wr_ptr;
    w_count_n  = r_count;
    w_age_n    = r_age;
    w_tmo_n    = r_tmo;
    w_new_n    = 1'b0;
    w_we       = 1'b0;
    if (i_clear) begin
      w_state_n  = S_LIVE;
      w_wr_ptr_n = '0;
      w_count_n  = '0;
      w_age_n    = '0;
      w_tmo_n    = '0;
    end else begin
      if (w_cap) begin
        w_we       = 1'b1;
        w_new_n    = 1'b1;
        w_wr_ptr_n = r_wr_ptr + AW'(1);
        if (r_count != CW'(DEPTH))
          w_count_n = r_count + CW'(1);
      end
      case (r_state)
        S_LIVE: begin
          w_age_n = '0;
          w_tmo_n = '0;
          if (w_btn_prev && r_count != '0)
            w_state_n = S_BROWSE;
        end
        default: begin
          if (w_btn_prev) begin
            w_tmo_n = '0;
            if ({1'b0, r_age} < r_count - CW'(1))
              w_age_n = r_age + AW'(1);
          end else if (w_btn_next) begin
            w_tmo_n = '0;
            if (r_age == '0)
              w_state_n = S_LIVE;
            else
              w_age_n = r_age - AW'(1);
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            w_state_n = S_LIVE;
            w_age_n   = '0;
            w_tmo_n   = '0;
          end else begin
            w_tmo_n = r_tmo + TW'(1);
          end
          // Keep pointing at the same entry as a new result pushes it one step older.
          if (w_cap && w_state_n == S_BROWSE && w_age_n != AW'(DEPTH - 1))
            w_age_n = w_age_n + AW'(1);
        end
      endcase
    end
  end

  assign w_idx = w_wr_ptr_n - AW'(1) - w_age_n;

  always_comb begin
    w_shown_n = i_number;
    if (w_state_n == S_BROWSE)
      w_shown_n = (w_we && w_idx == r_wr_ptr) ? i_number : r_hist[w_idx];
  end

  always_ff @(posedge i_clk) begin
    if (w_we)
      r_hist[r_wr_ptr] <= i_number;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_LIVE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
      r_tmo    <= '0;
      r_idle_d <= 1'b1;
      r_shown  <= 4'h0;
      r_seg    <= 7'b1000000;
      r_new    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_wr_ptr <= w_wr_ptr_n;
      r_count  <= w_count_n;
      r_age    <= w_age_n;
      r_tmo    <= w_tmo_n;
      r_idle_d <= i_idle;
      r_shown  <= w_shown_n;
      r_seg    <= glyph(w_shown_n);
      r_new    <= w_new_n;
    end
  end

  assign o_seg    = r_seg;
  assign o_shown  = r_shown;
  assign o_age    = r_age;
  assign o_count  = r_count;
  assign o_browse = (r_state == S_BROWSE);
  assign o_new    = r_new;

endmodule
